// File: rtl/pll_tick_gen.sv
// pll_tick_gen: multi-channel clock-enable generator running off the board
// reference clock. Each channel divides refclk by a runtime-programmable
// divider, emits a one-cycle tick at a programmable phase and a ~50 % duty
// level. Reconfiguration is double-buffered and applied only at the end of
// a period (or immediately when the channel is disabled) so outputs never
// glitch. `locked` imitates a PLL lock indication.
//
// Ports:
//   refclk    - sole clock, rising edge
//   rst_n     - asynchronous active-low reset
//   cfg_we    - config write strobe (one cycle per write)
//   cfg_ch    - target channel index
//   cfg_div   - new divider, 0 disables the channel
//   cfg_phase - new tick phase, must be < cfg_div when cfg_div != 0
//   cfg_err   - one-cycle pulse, the write in the previous cycle was rejected
//   tick      - per-channel one-cycle enable pulse
//   outclk    - per-channel registered level, high for ceil(div/2) cycles
//   locked    - settle period elapsed and no channel has a pending update

// Per-channel divider with shadow configuration.
module pll_tick_ch #(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic [DIV_W-1:0] wr_phase,
    output logic             tick,
    output logic             outclk,
    output logic             pending
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] phase_q, phase_d;
    logic [DIV_W-1:0] sdiv_q, sdiv_d;
    logic [DIV_W-1:0] sphase_q, sphase_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             outclk_q, outclk_d;

    logic             en;
    logic             wrap;
    logic             apply;
    logic [DIV_W:0]   half;

    always_comb begin
        en    = (div_q != '0);
        // A disabled channel counts as permanently at end of period so a
        // pending update lands on the very next edge.
        wrap  = en ? (cnt_q == div_q - DIV_W'(1)) : 1'b1;
        apply = pend_q && wrap;
        // ceil(div/2), one extra bit so div = all-ones does not overflow
        half  = ({1'b0, div_q} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

        cnt_d    = (!en || wrap) ? '0 : cnt_q + DIV_W'(1);
        div_d    = div_q;
        phase_d  = phase_q;
        sdiv_d   = sdiv_q;
        sphase_d = sphase_q;
        pend_d   = pend_q;

        // Apply consumes the shadow as it was before this edge; a write on
        // the same edge refills the shadow and keeps the channel pending.
        if (apply) begin
            div_d   = sdiv_q;
            phase_d = sphase_q;
            pend_d  = 1'b0;
        end
        if (wr) begin
            sdiv_d   = wr_div;
            sphase_d = wr_phase;
            pend_d   = 1'b1;
        end

        tick_d   = en && (cnt_q == phase_q);
        outclk_d = en && ({1'b0, cnt_q} < half);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            div_q    <= DIV_W'(DEFAULT_DIV);
            phase_q  <= '0;
            sdiv_q   <= '0;
            sphase_q <= '0;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
            outclk_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            phase_q  <= phase_d;
            sdiv_q   <= sdiv_d;
            sphase_q <= sphase_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
            outclk_q <= outclk_d;
        end
    end

    assign tick    = tick_q;
    assign outclk  = outclk_q;
    assign pending = pend_q;
endmodule

module pll_tick_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int LOCK_CYCLES = 1024,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DIV_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] outclk,
    output logic              locked
);
    localparam int LK_W = $clog2(LOCK_CYCLES + 1);

    logic [LK_W-1:0]   lockcnt_q, lockcnt_d;
    logic              locked_q, locked_d;
    logic              cfg_err_q, cfg_err_d;
    logic              cfg_bad;
    logic              cfg_ok;
    logic [NUM_CH-1:0] wr;
    logic [NUM_CH-1:0] pend;

    always_comb begin
        cfg_bad   = (32'(cfg_ch) >= 32'(NUM_CH)) ||
                    ((cfg_div != '0) && (cfg_phase >= cfg_div));
        cfg_ok    = cfg_we && !cfg_bad;
        cfg_err_d = cfg_we && cfg_bad;

        lockcnt_d = (lockcnt_q == LK_W'(LOCK_CYCLES)) ? lockcnt_q
                                                      : lockcnt_q + LK_W'(1);
        locked_d  = (lockcnt_q == LK_W'(LOCK_CYCLES)) && !(|pend);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = cfg_ok && (32'(cfg_ch) == 32'(i));

        pll_tick_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .refclk   (refclk),
            .rst_n    (rst_n),
            .wr       (wr[i]),
            .wr_div   (cfg_div),
            .wr_phase (cfg_phase),
            .tick     (tick[i]),
            .outclk   (outclk[i]),
            .pending  (pend[i])
        );
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lockcnt_q <= '0;
            locked_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            lockcnt_q <= lockcnt_d;
            locked_q  <= locked_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign locked  = locked_q;
    assign cfg_err = cfg_err_q;
endmodule
